// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

  // Default operand width (hi and lo are each this wide).
  localparam int unsigned MDU_WIDTH = 32;

  // Operation encodings as presented on the op port.
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // Control states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign conditioning for the MDU.
// Split mode (wide_i=0): hi and lo are negated independently.
// Wide mode (wide_i=1): {hi,lo} is negated as one 2*WIDTH value when neg_lo_i is set.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             wide_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] wide_neg;

  assign wide_neg = -{hi_i, lo_i};

  // Select between pass-through, split negation and full-width negation.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (wide_i) begin
      if (neg_lo_i) begin
        {hi_o, lo_o} = wide_neg;
      end
    end else begin
      if (neg_hi_i) begin
        hi_o = -hi_i;
      end
      if (neg_lo_i) begin
        lo_o = -lo_i;
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
// One iteration per clock; WIDTH iterations in CALC then one FIX cycle to commit.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  // m: multiplicand (mult) or divisor (div); acc/q: {high, low} working pair.
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] raw1_q, raw1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand conditioning at start.
  logic             start_signed;
  logic [WIDTH-1:0] abs1, abs2;

  assign start_signed = ~op[0];

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_abs (
    .wide_i   (1'b0),
    .neg_hi_i (start_signed & data1[WIDTH-1]),
    .neg_lo_i (start_signed & data2[WIDTH-1]),
    .hi_i     (data1),
    .lo_i     (data2),
    .hi_o     (abs1),
    .lo_o     (abs2)
  );

  // Result sign correction in FIX: whole product for mult, quotient/remainder for div.
  logic [WIDTH-1:0] fix_hi, fix_lo;

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_fix (
    .wide_i   (~op_q[1]),
    .neg_hi_i (sign1_q),
    .neg_lo_i (sign1_q ^ sign2_q),
    .hi_i     (acc_q),
    .lo_i     (q_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // Iteration arithmetic.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
  assign div_sub   = div_shift[WIDTH-1:0] - m_q;

  // Next-state logic for the FSM, datapath and HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    raw1_d  = raw1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d    = op;
          sign1_d = start_signed & data1[WIDTH-1];
          sign2_d = start_signed & data2[WIDTH-1];
          m_d     = op[1] ? abs2 : abs1;
          q_d     = op[1] ? abs1 : abs2;
          acc_d   = '0;
          raw1_d  = data1;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (op_q[1]) begin
          acc_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (op_q[1] && (m_q == '0)) begin
          lo_d = '1;
          hi_d = raw1_q;
        end else begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      raw1_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      raw1_q  <= raw1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table of operations plus hand-written sequences.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_iter #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .data1 (data1),
    .data2 (data2),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NumVec = 12;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded), check latency and results.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] eh, input logic [31:0] el);
    int k;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    data1 = d1;
    data2 = d2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
    check({name, " latency"}, k, 32'd33);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    @(posedge clk);
    #1;
    check({name, " done cleared"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first;
    logic [31:0] lo_before;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[7]  = '{MDU_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{MDU_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    data1 = '0;
    data2 = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;

    // Reset state.
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mthi / mtlo in IDLE, singly and together.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi lo untouched", lo, 32'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("both we hi", hi, 32'hA5A5A5A5);
    check("both we lo", lo, 32'hA5A5A5A5);

    // Vector table.
    for (int i = 0; i < NumVec; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
             vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Start ignored while busy, operand changes and mtlo while busy ignored.
    @(negedge clk);
    start = 1'b1;
    op    = MDU_MULTU;
    data1 = 32'd3;
    data2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lo_before = lo;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      start = (k == 10);
      lo_we = (k == 12);
      wdata = 32'hDEADBEEF;
      if (k == 10) begin
        op    = MDU_DIVU;
        data1 = 32'd9;
        data2 = 32'd3;
      end
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 20) check("busy lo hold", lo, lo_before);
    end
    start = 1'b0;
    lo_we = 1'b0;
    check("ignored start pulses", pulses, 32'd1);
    check("ignored start latency", first, 32'd33);
    check("ignored start hi", hi, 32'd0);
    check("ignored start lo", lo, 32'd15);

    // mthi on the same edge as start: written now, overwritten by the result.
    @(negedge clk);
    start = 1'b1;
    hi_we = 1'b1;
    wdata = 32'hCAFEF00D;
    op    = MDU_DIVU;
    data1 = 32'd50;
    data2 = 32'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    check("start+mthi hi", hi, 32'hCAFEF00D);
    check("start+mthi busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      #1;
    end
    check("start+mthi done", {31'd0, done}, 32'd1);
    check("start+mthi result hi", hi, 32'd2);
    check("start+mthi result lo", lo, 32'd6);

    // Reset mid-operation.
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h55AA55AA;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    start = 1'b1;
    op    = MDU_MULTU;
    data1 = 32'hFFFFFFFF;
    data2 = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post reset divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the execute stage, beside the 32-bit ALU.
- Fed by the same register-file operands (data1/data2); owns the HI/LO registers.
- HI/LO are read by the writeback mux for mfhi/mflo.
- Radix-2 shift-add multiply and restoring divide, one iteration per clock; control stalls the PC while busy=1.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH each; product is 2*WIDTH
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk     in   1      rising-edge clock
rst_n   in   1      asynchronous active-low reset
start   in   1      request; sampled only in IDLE
op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
data1   in   WIDTH  multiplicand / dividend (rs)
data2   in   WIDTH  multiplier / divisor (rt)
hi_we   in   1      mthi write strobe
lo_we   in   1      mtlo write strobe
wdata   in   WIDTH  mthi/mtlo data
busy    out  1      operation in progress
done    out  1      one-cycle completion pulse
hi      out  WIDTH  HI register
lo      out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, all internal operand/accumulator registers=0.
- Reset mid-operation aborts the operation; no partial result ever reaches hi/lo.
- States:
  - IDLE: busy=0. If start=1 at edge E: latch op, |data1|, |data2| and sign flags (signed ops only), plus raw data1; counter=0; go to CALC.
  - CALC: busy=1. One iteration per edge; counter increments. After the WIDTH-th iteration (edge E+WIDTH) go to FIX.
  - FIX: busy=1. At edge E+WIDTH+1: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Latency: done=1 and new hi/lo visible in the cycle after edge E+33 (WIDTH=32). done is high for exactly that one cycle. The next start is accepted at the edge that clears done.
- MULT/MULTU: {hi,lo} = 64-bit product.
  - Signed: negate the unsigned product (two's complement over 64 bits) when the operand signs differ.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed: quotient negative iff operand signs differ; remainder takes the dividend's sign; truncation toward zero.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divisor 0 (both DIV and DIVU): lo=0xFFFFFFFF, hi=raw data1. Same latency; no exception.
- Operands are latched at start; data1/data2/op changes during busy have no effect.
- start while busy=1: ignored, not queued.
- hi_we/lo_we:
  - In IDLE: hi/lo take wdata at the edge.
  - Both asserted: both registers written.
  - While busy=1: ignored.
  - At the same edge as start: the write happens; the operation still starts and later overwrites hi/lo.
- hi/lo hold their value at all other times. The mflo path reads them combinationally.

Decomposition:
- Shared package: op encodings (MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11), state encodings (IDLE, CALC, FIX), WIDTH default.
- One natural sub-module: mdu_sign_fix (combinational). Handles abs-value conditioning at start and the result negation/remainder-sign correction in FIX. Instantiated once for each direction.
- Iteration datapath and FSM stay in mdu_iter.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge E -> busy high after E; done pulse one cycle after E+33; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. Boundary divides:
   - DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007, same latency.
   - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
4. Start MULTU 3x5; pulse start=1 with DIVU 9/3 and changed operands at cycle 10 -> second request ignored; result hi=0, lo=15; exactly one done pulse.
5. In IDLE: hi_we=1 wdata=0x12345678 -> hi=0x12345678. While busy: lo_we=1 -> lo unchanged until completion.
6. Start MULTU, assert rst_n=0 at cycle 20 -> busy, done, hi, lo go to 0 immediately. After release, DIVU 100/7 -> lo=14, hi=2 with normal latency.
